// File: rtl/rasterizer_pkg.sv
// rtl/rasterizer_pkg.sv - shared widths, scanout state and pixel tag types
package rasterizer_pkg;

    localparam int ADDR_W          = 26;
    localparam int COLOR_W         = 24;
    localparam int BYTES_PER_PIXEL = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scanout_state_t;

    typedef struct packed {
        logic               sof;
        logic               eol;
        logic [COLOR_W-1:0] rgb;
    } pixel_tag_t;

endpackage

// File: rtl/scanout_fifo.sv
// rtl/scanout_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module scanout_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - raster-order frame buffer reader with credit-limited prefetch
module framebuffer_scanout
    import rasterizer_pkg::*;
#(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] frame_buffer_base,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic [3:0]        master_byteenable,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic [23:0]       pixel_data,
    output logic              pixel_sof,
    output logic              pixel_eol,
    output logic              underflow
);

    localparam int X_W   = $clog2(H_RES + 1);
    localparam int Y_W   = $clog2(V_RES + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int OS_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SUM_W = ((FC_W > OS_W) ? FC_W : OS_W) + 1;
    localparam logic [X_W-1:0]    X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BYTES_PER_PIXEL);

    scanout_state_t    state, state_next;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] base_latched;
    logic [ADDR_W-1:0] offset;
    logic              accept;
    logic              response;
    logic              credit_ok;
    logic              last_pixel;
    logic              first_popped;

    pixel_tag_t        fifo_in, fifo_out;
    logic [FC_W-1:0]   fifo_count;
    logic              fifo_empty, fifo_full, fifo_clear, fifo_push, fifo_pop;

    logic [1:0]        tag_in, tag_out;
    logic [OS_W-1:0]   outstanding;
    logic              tag_empty, tag_full;
    logic              unused_readdata;

    assign unused_readdata   = ^master_readdata[31:24];
    assign master_byteenable = 4'hF;
    assign master_address    = base_latched + offset;
    assign last_pixel        = (x == X_LAST) && (y == Y_LAST);
    assign accept            = master_read && !master_waitrequest;

    // The tag FIFO holds one entry per in-flight read, so its count is the outstanding count
    // and an empty tag FIFO marks any readdatavalid as stale.
    assign response  = master_readdatavalid && !tag_empty;
    assign tag_in    = {(x == '0) && (y == '0), x == X_LAST};
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding) < SUM_W'(FIFO_DEPTH))
                       && !tag_full && !fifo_full;

    assign fifo_in     = '{sof: tag_out[1], eol: tag_out[0], rgb: master_readdata[23:0]};
    assign fifo_push   = response && (state == SCAN);
    assign pixel_valid = !fifo_empty && (state != DRAIN);
    assign fifo_pop    = pixel_valid && pixel_ready;
    assign pixel_data  = pixel_valid ? fifo_out.rgb : '0;
    assign pixel_sof   = pixel_valid && fifo_out.sof;
    assign pixel_eol   = pixel_valid && fifo_out.eol;

    always_comb begin
        state_next  = state;
        master_read = 1'b0;
        fifo_clear  = 1'b0;
        unique case (state)
            IDLE:  if (enable) state_next = SCAN;
            SCAN: begin
                if (!enable) state_next = DRAIN;
                else         master_read = credit_ok;
            end
            DRAIN: begin
                fifo_clear = 1'b1;
                if (outstanding == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            offset       <= '0;
            base_latched <= '0;
            first_popped <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && enable) begin
                base_latched <= frame_buffer_base;
                x            <= '0;
                y            <= '0;
                offset       <= '0;
                first_popped <= 1'b0;
            end else if (accept) begin
                if (last_pixel) begin
                    base_latched <= frame_buffer_base;
                    x            <= '0;
                    y            <= '0;
                    offset       <= '0;
                end else begin
                    offset <= offset + STRIDE;
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + Y_W'(1);
                    end else begin
                        x <= x + X_W'(1);
                    end
                end
            end
            if (fifo_pop && fifo_out.sof) first_popped <= 1'b1;
            if (state == SCAN && pixel_ready && fifo_empty && first_popped) underflow <= 1'b1;
        end
    end

    scanout_fifo #(.WIDTH($bits(pixel_tag_t)), .DEPTH(FIFO_DEPTH)) u_pixel_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    scanout_fifo #(.WIDTH(2), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .push      (accept),
        .push_data (tag_in),
        .pop       (response),
        .pop_data  (tag_out),
        .count     (outstanding),
        .empty     (tag_empty),
        .full      (tag_full)
    );

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - scoreboard bench with an Avalon memory model for framebuffer_scanout
module tb_framebuffer_scanout;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int FD  = 16;
    localparam int MO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [25:0] frame_buffer_base = '0;
    logic [25:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_waitrequest = 1'b0;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_sof;
    logic        pixel_eol;
    logic        underflow;

    framebuffer_scanout #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .frame_buffer_base    (frame_buffer_base),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_byteenable    (master_byteenable),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .pixel_valid          (pixel_valid),
        .pixel_ready          (pixel_ready),
        .pixel_data           (pixel_data),
        .pixel_sof            (pixel_sof),
        .pixel_eol            (pixel_eol),
        .underflow            (underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [25:0] addr;
        int          due;
    } rsp_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] rgb;
    } pix_t;

    rsp_t        mq[$];
    pix_t        sb[$];
    rsp_t        rsp_head;
    pix_t        exp_pix;
    logic [25:0] exp_addr;
    logic [25:0] exp_base = '0;
    logic [25:0] stalled_addr = '0;
    int          exp_idx = 0;
    int          cyc = 0;
    int          mem_latency = 0;
    int          accepts = 0;
    int          pops = 0;
    int          max_os = 0;
    int          os_now = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          rdv_seen = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] mem_rgb(input logic [25:0] addr);
        return addr[23:0] ^ 24'hC3A55A;
    endfunction

    // Avalon slave model plus output monitor; inputs change on the falling edge,
    // then the settled outputs describe what the next rising edge commits.
    always @(negedge clock) begin
        cyc++;
        if (master_readdatavalid) rsp_head = mq.pop_front();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = {8'hEE, mem_rgb(mq[0].addr)};
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = 32'h0;
        end
        if (stall_left > 0 && accepts == stall_idx) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = 1'b0;
        end
        #1;
        if (master_readdatavalid && !reset) rdv_seen++;
        exp_addr = exp_base + 26'(4 * exp_idx);
        if (master_read && master_waitrequest) begin
            stall_seen++;
            stalled_addr = master_address;
            check("stall_addr", master_address, exp_addr);
        end
        if (master_read && !master_waitrequest && !reset) begin
            check("rd_addr", master_address, exp_addr);
            exp_pix = '{sof: exp_idx == 0, eol: (exp_idx % H) == H - 1, rgb: mem_rgb(exp_addr)};
            sb.push_back(exp_pix);
            mq.push_back('{addr: master_address, due: cyc + 1 + mem_latency});
            accepts++;
            exp_idx = (exp_idx + 1) % (H * V);
            os_now = mq.size() - (master_readdatavalid ? 1 : 0);
            if (os_now > max_os) max_os = os_now;
        end
        if (pixel_valid && pixel_ready && !reset) begin
            if (sb.size() == 0) begin
                check("unexpected_pixel", pixel_valid, 1'b0);
            end else begin
                exp_pix = sb.pop_front();
                check("pix_sof", pixel_sof, exp_pix.sof);
                check("pix_eol", pixel_eol, exp_pix.eol);
                check("pix_rgb", pixel_data, exp_pix.rgb);
                pops++;
            end
        end
    end

    task automatic start_scan(input logic [25:0] base, input int latency, input logic ready);
        frame_buffer_base = base;
        exp_base          = base;
        exp_idx           = 0;
        mem_latency       = latency;
        pixel_ready       = ready;
        enable            = 1'b1;
    endtask

    task automatic wait_pops(input string tag, input int target, input int limit);
        for (int i = 0; i < limit && pops < target; i++) @(negedge clock);
        check(tag, pops >= target, 1'b1);
    endtask

    task automatic stop_and_idle(input string tag);
        pixel_ready = 1'b0;
        enable      = 1'b0;
        for (int i = 0; i < 200 && mq.size() > 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        #2;
        check({tag, "_drained"}, mq.size(), 0);
        check({tag, "_idle_read"}, master_read, 1'b0);
        check({tag, "_idle_valid"}, pixel_valid, 1'b0);
        sb.delete();
    endtask

    int a0, a1, p0, r0;

    initial begin
        repeat (3) @(negedge clock);
        #2;
        check("rst_read", master_read, 1'b0);
        check("rst_addr", master_address, 26'h0);
        check("rst_be", master_byteenable, 4'hF);
        check("rst_valid", pixel_valid, 1'b0);
        check("rst_data", {pixel_sof, pixel_eol, pixel_data}, 26'h0);
        check("rst_underflow", underflow, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Two full frames back to back from zero-latency memory.
        p0 = pops;
        start_scan(26'h100, 0, 1'b1);
        wait_pops("t1_two_frames", p0 + 2 * H * V, 200);
        check("t1_underflow", underflow, 1'b0);
        stop_and_idle("t1");

        // Second read stalled by waitrequest for three cycles.
        stall_seen = 0;
        stall_idx  = accepts + 1;
        stall_left = 3;
        @(negedge clock);
        p0 = pops;
        start_scan(26'h100, 0, 1'b1);
        wait_pops("t2_frame", p0 + H * V, 200);
        check("t2_stall_cycles", stall_seen, 3);
        check("t2_stall_addr", stalled_addr, 26'h104);
        stop_and_idle("t2");

        // Display back-pressure: prefetch must stop at exactly the FIFO depth.
        max_os = 0;
        a0 = accepts;
        p0 = pops;
        start_scan(26'h2000, 0, 1'b0);
        repeat (200) @(negedge clock);
        check("t3_fetch_count", accepts - a0, FD);
        check("t3_max_os_ok", max_os <= MO, 1'b1);
        check("t3_no_pop", pops, p0);
        pixel_ready = 1'b1;
        wait_pops("t3_release", p0 + FD + H * V, 300);
        stop_and_idle("t3");

        // Enable dropped with five reads in flight and a stalled sixth request.
        a0 = accepts;
        stall_idx  = a0 + 5;
        stall_left = 1000;
        @(negedge clock);
        start_scan(26'h0300, 20, 1'b0);
        for (int i = 0; i < 100 && accepts < a0 + 5; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("t4_inflight", mq.size(), 5);
        enable = 1'b0;
        a1 = accepts;
        @(negedge clock);
        stall_left = 0;
        for (int i = 0; i < 100 && mq.size() > 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        #2;
        check("t4_no_new_reads", accepts, a1);
        check("t4_valid_low", pixel_valid, 1'b0);
        sb.delete();
        p0 = pops;
        start_scan(26'h0300, 0, 1'b1);
        wait_pops("t4_restart", p0 + H * V, 200);
        stop_and_idle("t4");

        // Reset with reads in flight; the stale responses must be ignored.
        a0 = accepts;
        start_scan(26'h3000, 10, 1'b0);
        for (int i = 0; i < 100 && accepts < a0 + 4; i++) @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_idx = 0;
        r0 = rdv_seen;
        for (int i = 0; i < 60 && mq.size() > 0; i++) begin
            @(negedge clock);
            #2;
            check("t5_valid_low", pixel_valid, 1'b0);
        end
        repeat (2) @(negedge clock);
        #2;
        check("t5_stale_seen", rdv_seen > r0, 1'b1);
        check("t5_addr", master_address, 26'h0);
        check("t5_data", {pixel_sof, pixel_eol, pixel_data}, 26'h0);
        check("t5_underflow", underflow, 1'b0);
        p0 = pops;
        start_scan(26'h3000, 0, 1'b1);
        wait_pops("t5_recover", p0 + H * V, 200);
        stop_and_idle("t5");

        // Slow memory with a ready display: underflow sets and sticks until reset.
        check("t6_underflow_pre", underflow, 1'b0);
        max_os = 0;
        start_scan(26'h0400, 20, 1'b1);
        repeat (150) @(negedge clock);
        #2;
        check("t6_underflow_set", underflow, 1'b1);
        check("t6_max_os", max_os, MO);
        stop_and_idle("t6");
        check("t6_underflow_sticky", underflow, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #2;
        check("t6_underflow_cleared", underflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
